// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline-control definitions for the RV32 hazard sequencer:
// PC-select encodings, FSM states and the packed control-output bundle.
`default_nettype none

package core_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_JALR = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_write;
    logic       ex_mem_write;
    logic       mem_wb_write;
    logic       if_id_flush;
    logic       id_ex_flush;
  } ctrl_t;

  // Field order: {pc_sel, pc/if_id/id_ex/ex_mem/mem_wb write, if_id/id_ex flush}
  localparam ctrl_t CTRL_RUN    = ctrl_t'({PCSEL_SEQ, 5'b11111, 2'b00});
  localparam ctrl_t CTRL_HOLD   = ctrl_t'({PCSEL_SEQ, 5'b00000, 2'b00});
  localparam ctrl_t CTRL_MDU    = ctrl_t'({PCSEL_SEQ, 5'b00001, 2'b00});
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({PCSEL_SEQ, 5'b00111, 2'b01});
  localparam ctrl_t CTRL_RESET  = ctrl_t'({PCSEL_SEQ, 5'b00000, 2'b11});

  function automatic ctrl_t ctrl_redirect(input logic [1:0] sel);
    return ctrl_t'({sel, 5'b11111, 2'b11});
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sequencer_if.sv
// Pipeline-side view of the hazard sequencer: hazard inputs from ID/EX/MEM
// and the PC-select, write-enable, flush and counter outputs.
`default_nettype none

interface hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       branch_ctrl;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_mdu;
  logic             mdu_done;
  logic             dmem_busy;

  logic [1:0]       pc_sel;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output branch_ctrl, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_mem_read, ex_mdu, mdu_done, dmem_busy,
    input  pc_sel, pc_write, if_id_write, id_ex_write, ex_mem_write,
           mem_wb_write, if_id_flush, id_ex_flush, mdu_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  branch_ctrl, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_mem_read, ex_mdu, mdu_done, dmem_busy,
    output pc_sel, pc_write, if_id_write, id_ex_write, ex_mem_write,
           mem_wb_write, if_id_flush, id_ex_flush, mdu_timeout,
           stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating event counter with asynchronous active-low clear.
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_sequencer.sv
// Pipeline-control FSM for the 5-stage RV32 core: resolves memory, MDU,
// redirect and load-use hazards into PC select, stage enables and flushes.
`default_nettype none

module hazard_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MDU_MAX_CYC = 34
) (
  input  logic               clk,
  input  logic               rst,
  hazard_sequencer_if.slave  bus
);

  localparam int MDU_CYC_W = $clog2(MDU_MAX_CYC + 1);
  localparam logic [MDU_CYC_W-1:0] MDU_CYC_MAX = MDU_CYC_W'(MDU_MAX_CYC);

  state_e               state_q, state_d;
  logic [1:0]           pend_sel_q, pend_sel_d;
  logic [MDU_CYC_W-1:0] mdu_cyc_q, mdu_cyc_d;
  logic                 mdu_timeout_q, mdu_timeout_d;

  ctrl_t      w_ctrl;
  logic       w_redirect;
  logic [1:0] w_sel;
  logic       w_eval;
  logic       w_br_valid;
  logic       w_load_use;
  logic       w_mdu_start;

  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  assign w_br_valid  = (bus.branch_ctrl == PCSEL_BR) || (bus.branch_ctrl == PCSEL_JALR);
  assign w_mdu_start = bus.ex_mdu && !bus.mdu_done;
  assign w_load_use  = bus.ex_mem_read && (bus.ex_rd != REG_X0) &&
                       ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                        (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    w_ctrl        = CTRL_RUN;
    w_redirect    = 1'b0;
    w_sel         = bus.branch_ctrl;
    w_eval        = 1'b0;
    state_d       = state_q;
    pend_sel_d    = pend_sel_q;
    mdu_cyc_d     = mdu_cyc_q;
    mdu_timeout_d = mdu_timeout_q;

    case (state_q)
      ST_RUN: w_eval = 1'b1;

      ST_MEM_WAIT: begin
        if (bus.dmem_busy) begin
          w_ctrl = CTRL_HOLD;
        end else begin
          state_d    = ST_RUN;
          pend_sel_d = PCSEL_SEQ;
          // A redirect captured on entry wins over anything decoded now.
          if (pend_sel_q != PCSEL_SEQ) begin
            w_redirect = 1'b1;
            w_sel      = pend_sel_q;
          end else begin
            w_eval = 1'b1;
          end
        end
      end

      ST_MDU_WAIT: begin
        if (mdu_cyc_q != MDU_CYC_MAX) begin
          mdu_cyc_d = mdu_cyc_q + 1'b1;
        end
        if (bus.dmem_busy) begin
          w_ctrl = CTRL_HOLD;
        end else if (bus.mdu_done || (mdu_cyc_q == MDU_CYC_MAX)) begin
          state_d = ST_RUN;
          if (!bus.mdu_done) begin
            mdu_timeout_d = 1'b1;
          end
          // EX was held, so a redirect it carries is only acted on now.
          w_redirect = w_br_valid;
        end else begin
          w_ctrl = CTRL_MDU;
        end
      end

      default: state_d = ST_RUN;
    endcase

    if (w_eval) begin
      if (bus.dmem_busy) begin
        w_ctrl     = CTRL_HOLD;
        state_d    = ST_MEM_WAIT;
        pend_sel_d = w_br_valid ? bus.branch_ctrl : PCSEL_SEQ;
      end else if (w_mdu_start) begin
        w_ctrl    = CTRL_MDU;
        state_d   = ST_MDU_WAIT;
        mdu_cyc_d = MDU_CYC_W'(1);
      end else if (w_br_valid) begin
        w_redirect = 1'b1;
      end else if (w_load_use) begin
        w_ctrl = CTRL_BUBBLE;
      end
    end

    if (w_redirect) begin
      w_ctrl = ctrl_redirect(w_sel);
    end

    if (!rst) begin
      w_ctrl = CTRL_RESET;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      pend_sel_q    <= PCSEL_SEQ;
      mdu_cyc_q     <= '0;
      mdu_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_sel_q    <= pend_sel_d;
      mdu_cyc_q     <= mdu_cyc_d;
      mdu_timeout_q <= mdu_timeout_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (!w_ctrl.pc_write),
    .count_o (w_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_redirect),
    .count_o (w_flush_cnt)
  );

  assign bus.pc_sel       = w_ctrl.pc_sel;
  assign bus.pc_write     = w_ctrl.pc_write;
  assign bus.if_id_write  = w_ctrl.if_id_write;
  assign bus.id_ex_write  = w_ctrl.id_ex_write;
  assign bus.ex_mem_write = w_ctrl.ex_mem_write;
  assign bus.mem_wb_write = w_ctrl.mem_wb_write;
  assign bus.if_id_flush  = w_ctrl.if_id_flush;
  assign bus.id_ex_flush  = w_ctrl.id_ex_flush;
  assign bus.mdu_timeout  = mdu_timeout_q;
  assign bus.stall_cnt    = w_stall_cnt;
  assign bus.flush_cnt    = w_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer.
`default_nettype none

module tb_hazard_sequencer;

  localparam int CNT_W = 16;

  // {pc_sel[1:0], pc/if_id/id_ex/ex_mem/mem_wb write, if_id/id_ex flush}
  localparam logic [8:0] E_RUN  = 9'b00_11111_00;
  localparam logic [8:0] E_HOLD = 9'b00_00000_00;
  localparam logic [8:0] E_MDU  = 9'b00_00001_00;
  localparam logic [8:0] E_BUB  = 9'b00_00111_01;
  localparam logic [8:0] E_BR   = 9'b01_11111_11;
  localparam logic [8:0] E_JALR = 9'b10_11111_11;
  localparam logic [8:0] E_RST  = 9'b00_00000_11;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  hazard_sequencer #(.CNT_W(CNT_W), .MDU_MAX_CYC(34)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs_ctrl();
    return {bus.pc_sel, bus.pc_write, bus.if_id_write, bus.id_ex_write,
            bus.ex_mem_write, bus.mem_wb_write, bus.if_id_flush, bus.id_ex_flush};
  endfunction

  task automatic idle();
    bus.branch_ctrl = 2'b00;
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_mem_read = 1'b0;
    bus.ex_mdu      = 1'b0;
    bus.mdu_done    = 1'b0;
    bus.dmem_busy   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; expectation goes into the scoreboard, the
  // combinational outputs are compared mid-cycle, then the clock advances.
  task automatic cyc(input string tag, input logic [8:0] exp);
    exp_t e;
    logic [8:0] o;
    sb.push_back('{tag, exp});
    #2;
    o = obs_ctrl();
    e = sb.pop_front();
    vectors++;
    assert (o === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", e.tag, o, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic counts(input string tag, input int stall, input int flush, input logic tmo);
    check({tag, "_stall"}, 32'(bus.stall_cnt), 32'(stall));
    check({tag, "_flush"}, 32'(bus.flush_cnt), 32'(flush));
    check({tag, "_tmo"},   32'(bus.mdu_timeout), 32'(tmo));
  endtask

  initial begin
    idle();
    #1;
    check("reset_ctrl", 32'(obs_ctrl()), 32'(E_RST));
    counts("reset", 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    cyc("idle", E_RUN);
    counts("idle", 0, 0, 1'b0);

    // Load-use on rs2, then the load has moved on
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
    bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd5; bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1;
    cyc("load_use", E_BUB);
    counts("load_use", 1, 0, 1'b0);
    bus.ex_mem_read = 1'b0;
    cyc("after_bubble", E_RUN);

    // x0 destination and unused-operand matches never stall
    idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd0;
    cyc("x0_no_stall", E_RUN);
    idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_rs2 = 5'd9;
    cyc("unused_src", E_RUN);
    counts("no_stall", 1, 0, 1'b0);

    // JALR redirect, then reserved encoding 11
    idle(); bus.branch_ctrl = 2'b10;
    cyc("jalr", E_JALR);
    counts("jalr", 1, 1, 1'b0);
    bus.branch_ctrl = 2'b11;
    cyc("bctl_11", E_RUN);

    // Branch under a 3-cycle memory stall, with a load-use on the release
    idle(); bus.branch_ctrl = 2'b01; bus.dmem_busy = 1'b1;
    cyc("mem_busy1", E_HOLD);
    bus.branch_ctrl = 2'b00;
    cyc("mem_busy2", E_HOLD);
    cyc("mem_busy3", E_HOLD);
    bus.dmem_busy = 1'b0;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd3;
    cyc("mem_release_br", E_BR);
    counts("mem_wait", 4, 2, 1'b0);

    // MDU with coincident branch, memory stall mid-wait, done after 5 stalls
    idle(); bus.ex_mdu = 1'b1; bus.branch_ctrl = 2'b01;
    cyc("mdu_entry", E_MDU);
    cyc("mdu_wait2", E_MDU);
    bus.dmem_busy = 1'b1;
    cyc("mdu_mem_busy", E_HOLD);
    bus.dmem_busy = 1'b0;
    cyc("mdu_wait4", E_MDU);
    cyc("mdu_wait5", E_MDU);
    bus.mdu_done = 1'b1;
    cyc("mdu_done_br", E_BR);
    idle();
    cyc("mdu_back_run", E_RUN);
    counts("mdu", 9, 3, 1'b0);

    // MDU that never completes
    bus.ex_mdu = 1'b1;
    for (int i = 0; i < 34; i++) begin
      cyc($sformatf("mdu_to_%0d", i), E_MDU);
    end
    counts("mdu_pre_to", 43, 3, 1'b0);
    cyc("mdu_to_release", E_RUN);
    counts("mdu_to", 43, 3, 1'b1);
    idle();
    cyc("after_to", E_RUN);
    check("to_sticky", 32'(bus.mdu_timeout), 32'd1);

    // Asynchronous reset in the middle of an MDU wait
    bus.ex_mdu = 1'b1;
    cyc("mdu2_entry", E_MDU);
    cyc("mdu2_wait", E_MDU);
    rst = 1'b0;
    cyc("rst_mid_mdu", E_RST);
    counts("rst_mid", 0, 0, 1'b0);
    rst = 1'b1;
    idle();
    cyc("post_rst_run", E_RUN);
    counts("post_rst", 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
